lstm_seq_ctrl: RTL and testbench

Sequencer that runs one LSTM layer over a whole feature sequence by driving the registered single-step `lstm` cell. It fetches column vectors x_t from the upstream feature buffer and feeds h/c state back step by step, zeroing that state at sequence start. Each h_t is streamed to the downstream classifier/CTC stage over a valid/ready handshake. It sits between the CNN feature buffer and the `lstm` cell instance.

---
 rtl/lstm_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_seq_ctrl.sv
// Sequencer that runs one LSTM layer over a feature sequence through a registered lstm cell.
// Optional backward traversal (BiLSTM reverse pass) is enabled by defining LSTM_SEQ_REVERSE_EN.
module lstm_seq_ctrl #(
  parameter int M          = 16,
  parameter int N          = 32,
  parameter int DATA_WIDTH = 16,
  parameter int T_MAX      = 64,
  parameter int ADDR_W     = 6,
  parameter int CELL_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W:0]              seq_len,
  output logic                         busy,
  output logic                         done,
  output logic                         x_req,
  output logic [ADDR_W-1:0]            x_addr,
  input  logic                         x_valid,
  input  logic [N*DATA_WIDTH-1:0]      x_data,
  output logic [N*DATA_WIDTH-1:0]      xt,
  output logic [M*DATA_WIDTH-1:0]      htI,
  output logic [M*DATA_WIDTH-1:0]      ctI,
  input  logic [M*DATA_WIDTH-1:0]      cell_h,
  input  logic [M*DATA_WIDTH-1:0]      cell_c,
  output logic                         h_valid,
  input  logic                         h_ready,
  output logic [M*DATA_WIDTH-1:0]      h_data,
  output logic [ADDR_W-1:0]            h_idx,
  output logic                         h_last
);

  localparam int              CNT_W = (CELL_LAT < 1) ? 1 : $clog2(CELL_LAT + 1);
  localparam logic [ADDR_W:0] LMAX  = (ADDR_W + 1)'(T_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CALC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDR_W:0]           r_len;
  logic [ADDR_W:0]           r_step;
  logic [CNT_W-1:0]          r_cnt;
  logic [N*DATA_WIDTH-1:0]   r_xt;
  logic [M*DATA_WIDTH-1:0]   r_h;
  logic [M*DATA_WIDTH-1:0]   r_c;
  logic [ADDR_W:0]           w_len_start;
  logic [ADDR_W-1:0]         w_addr;
  logic                      w_last;

  assign w_len_start = (seq_len > LMAX) ? LMAX : seq_len;
  assign w_last      = (r_step == (r_len - (ADDR_W + 1)'(1)));

`ifdef LSTM_SEQ_REVERSE_EN
  // Low-bit modular arithmetic is exact here because L-1-step never goes negative.
  assign w_addr = r_len[ADDR_W-1:0] - ADDR_W'(1) - r_step[ADDR_W-1:0];
`else
  assign w_addr = r_step[ADDR_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_len_start == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (x_valid) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (h_ready) begin
          w_state_nxt = w_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_step <= '0;
      r_cnt  <= '0;
      r_xt   <= '0;
      r_h    <= '0;
      r_c    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len  <= w_len_start;
            r_step <= '0;
            r_h    <= '0;
            r_c    <= '0;
          end
        end
        S_FETCH: begin
          if (x_valid) begin
            r_xt  <= x_data;
            r_cnt <= CNT_W'(CELL_LAT);
          end
        end
        S_CALC: begin
          // The cell output is sampled on the edge closing the cycle where the counter is zero.
          if (r_cnt == '0) begin
            r_h <= cell_h;
            r_c <= cell_c;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_EMIT: begin
          if (h_ready && !w_last) begin
            r_step <= r_step + (ADDR_W + 1)'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign x_req   = (r_state == S_FETCH);
  assign h_valid = (r_state == S_EMIT);
  assign x_addr  = x_req ? w_addr : '0;
  assign h_idx   = h_valid ? w_addr : '0;
  assign h_last  = h_valid & w_last;
  assign xt      = r_xt;
  assign htI     = r_h;
  assign ctI     = r_c;
  assign h_data  = r_h;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl: a behavioural cell plus a step-level reference model.
module tb_lstm_seq_ctrl;

  localparam int M        = 16;
  localparam int N        = 32;
  localparam int DW       = 16;
  localparam int T_MAX    = 64;
  localparam int ADDR_W   = 6;
  localparam int CELL_LAT = 1;
  localparam int MW       = M * DW;
  localparam int NW       = N * DW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   seq_len = '0;
  logic              busy, done, x_req, h_valid, h_last;
  logic [ADDR_W-1:0] x_addr, h_idx;
  logic              x_valid = 1'b0;
  logic [NW-1:0]     x_data = '0;
  logic [NW-1:0]     xt;
  logic [MW-1:0]     htI, ctI, h_data;
  logic [MW-1:0]     cell_h = '0;
  logic [MW-1:0]     cell_c = '0;
  logic              h_ready = 1'b0;

  logic [NW-1:0]     xmem [T_MAX];
  int                n_checks = 0;
  int                n_fail = 0;
  int                g_last_idx;

  always #5 clk = ~clk;

  lstm_seq_ctrl #(
    .M(M), .N(N), .DATA_WIDTH(DW), .T_MAX(T_MAX), .ADDR_W(ADDR_W), .CELL_LAT(CELL_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len),
    .busy(busy), .done(done), .x_req(x_req), .x_addr(x_addr),
    .x_valid(x_valid), .x_data(x_data), .xt(xt), .htI(htI), .ctI(ctI),
    .cell_h(cell_h), .cell_c(cell_c), .h_valid(h_valid), .h_ready(h_ready),
    .h_data(h_data), .h_idx(h_idx), .h_last(h_last)
  );

  function automatic logic [MW-1:0] fh(input logic [NW-1:0] x, input logic [MW-1:0] h,
                                       input logic [MW-1:0] c);
    return x[MW-1:0] ^ {h[MW-2:0], h[MW-1]} ^ (c + MW'(1));
  endfunction

  function automatic logic [MW-1:0] fc(input logic [NW-1:0] x, input logic [MW-1:0] h,
                                       input logic [MW-1:0] c);
    return (x[NW-1 -: MW] + h) ^ c;
  endfunction

  function automatic logic [NW-1:0] rnd_x();
    logic [NW-1:0] v;
    for (int i = 0; i < NW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] tb_addr(input int step, input int len);
`ifdef LSTM_SEQ_REVERSE_EN
    return ADDR_W'(len - 1 - step);
`else
    return ADDR_W'(step + 0 * len);
`endif
  endfunction

  // Behavioural single-step cell with one register stage
  always @(posedge clk) begin
    cell_h <= fh(xt, htI, ctI);
    cell_c <= fc(xt, htI, ctI);
  end

  task automatic run_seq(input string name, input int sl, input int max_xlat, input int min_stall,
                         input int max_stall, input bit chk_timing, input bit poke_start);
    int L, step, cyc, xwait, stall, beats, fetches;
    bit fin, exp_req, hv_seen, poked;
    logic [MW-1:0] mh, mc, nh, nc;
    logic [NW-1:0] xs;
    L = (sl > T_MAX) ? T_MAX : sl;
    step = 0; beats = 0; fetches = 0; fin = 0; exp_req = 0; hv_seen = 0; poked = 0;
    mh = '0; mc = '0; nh = '0; nc = '0;
    xwait = $urandom_range(max_xlat, 0);
    stall = $urandom_range(max_stall, min_stall);
    @(negedge clk);
    start = 1'b1; seq_len = (ADDR_W + 1)'(sl); x_valid = 1'b0; h_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; seq_len = (ADDR_W + 1)'($urandom);
    cyc = 1;
    while (!fin && cyc < 4000) begin
      if (start) start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL %s busy cyc=%0d got=%b exp=1", name, cyc, busy);
      end
      if (exp_req) begin
        n_checks++;
        if (x_req !== 1'b1) begin
          n_fail++; $display("FAIL %s req_after_hs cyc=%0d got=%b exp=1", name, cyc, x_req);
        end
        exp_req = 0;
      end
      if (x_req) begin
        n_checks++;
        if (x_addr !== tb_addr(step, L) || htI !== mh || ctI !== mc || h_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s fetch step=%0d addr got=%0d exp=%0d state_ok=%b", name, step,
                   x_addr, tb_addr(step, L), (htI === mh && ctI === mc));
        end
        if (xwait == 0) begin
          xs = xmem[tb_addr(step, L)];
          x_valid = 1'b1; x_data = xs;
          nh = fh(xs, mh, mc); nc = fc(xs, mh, mc);
          fetches++;
        end else begin
          x_valid = 1'b0; x_data = rnd_x(); xwait--;
        end
      end else begin
        x_valid = 1'($urandom_range(1, 0)); x_data = rnd_x();
      end
      if (h_valid) begin
        if (!hv_seen && chk_timing) begin
          n_checks++;
          if (cyc !== 1 + step * (CELL_LAT + 3) + CELL_LAT + 2) begin
            n_fail++; $display("FAIL %s hv_cycle step=%0d got=%0d exp=%0d", name, step, cyc,
                               1 + step * (CELL_LAT + 3) + CELL_LAT + 2);
          end
        end
        hv_seen = 1;
        n_checks++;
        if (h_data !== nh || h_idx !== tb_addr(step, L) || x_req !== 1'b0 ||
            h_last !== ((step == L - 1) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL %s emit step=%0d idx got=%0d exp=%0d last got=%b exp=%b data_ok=%b",
                   name, step, h_idx, tb_addr(step, L), h_last, (step == L - 1), h_data === nh);
        end
        if (h_last) g_last_idx = int'(h_idx);
        if (poke_start && !poked && stall > 0) begin
          start = 1'b1; seq_len = (ADDR_W + 1)'(1); poked = 1;
        end
        if (stall > 0) begin
          h_ready = 1'b0; stall--;
        end else begin
          h_ready = 1'b1;
          mh = nh; mc = nc; beats++;
          if (step != L - 1) exp_req = 1;
          step++; hv_seen = 0;
          xwait = $urandom_range(max_xlat, 0);
          stall = $urandom_range(max_stall, min_stall);
        end
      end else begin
        h_ready = 1'($urandom_range(1, 0));
      end
      if (done) begin
        n_checks++;
        if (beats !== L || fetches !== L) begin
          n_fail++; $display("FAIL %s counts beats=%0d fetches=%0d exp=%0d", name, beats, fetches, L);
        end
        if (chk_timing) begin
          n_checks++;
          if (cyc !== ((L == 0) ? 1 : L * (CELL_LAT + 3) + 1)) begin
            n_fail++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, cyc,
                               (L == 0) ? 1 : L * (CELL_LAT + 3) + 1);
          end
        end
        fin = 1;
      end
      @(negedge clk);
      cyc++;
    end
    if (start) start = 1'b0;
    n_checks++;
    if (!fin) begin
      n_fail++; $display("FAIL %s timeout got=no_done exp=done", name);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || htI !== mh || ctI !== mc) begin
      n_fail++; $display("FAIL %s after_done busy=%b done=%b exp=0/0 state_kept=%b", name, busy,
                         done, (htI === mh && ctI === mc));
    end
  endtask

  task automatic test_reset();
    int n;
    n_checks++;
    if ({busy, done, x_req, h_valid, h_last} !== 5'b0 || x_addr !== '0 || h_idx !== '0 ||
        xt !== '0 || htI !== '0 || ctI !== '0) begin
      n_fail++; $display("FAIL reset_init ctrl got=%b exp=00000", {busy, done, x_req, h_valid, h_last});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; seq_len = (ADDR_W + 1)'(5); h_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(x_req && x_addr == tb_addr(1, 5)) && n < 50) begin
      x_valid = 1'b1; x_data = xmem[x_addr];
      @(negedge clk); n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++; $display("FAIL reset_reach_step1 got=timeout exp=x_req");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, x_req, h_valid, h_last} !== 5'b0 || x_addr !== '0 || h_idx !== '0 ||
        xt !== '0 || htI !== '0 || ctI !== '0 || h_data !== '0) begin
      n_fail++; $display("FAIL reset_abort ctrl got=%b exp=00000 xt0=%b htI0=%b ctI0=%b",
                         {busy, done, x_req, h_valid, h_last}, xt === '0, htI === '0, ctI === '0);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b1; x_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_done got=%b%b exp=00", done, busy);
      end
    end
  endtask

  task automatic test_basic();
    run_seq("seq3", 3, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_zero_len();
    run_seq("seq0", 0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_clamp();
    g_last_idx = -1;
    run_seq("clamp", 100, 1, 0, 1, 1'b0, 1'b0);
    n_checks++;
    if (g_last_idx !== int'(tb_addr(T_MAX - 1, T_MAX))) begin
      n_fail++; $display("FAIL clamp_last_idx got=%0d exp=%0d", g_last_idx,
                         tb_addr(T_MAX - 1, T_MAX));
    end
  endtask

  task automatic test_backpressure();
    run_seq("stall", 4, 0, 5, 5, 1'b0, 1'b1);
  endtask

  task automatic test_reverse_order();
    g_last_idx = -1;
    run_seq("len4", 4, 0, 0, 0, 1'b1, 1'b0);
    n_checks++;
    if (g_last_idx !== int'(tb_addr(3, 4))) begin
      n_fail++; $display("FAIL len4_last_idx got=%0d exp=%0d", g_last_idx, tb_addr(3, 4));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_seq("rand", $urandom_range(20, 1), $urandom_range(3, 0), 0, $urandom_range(3, 0),
              1'b0, 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    for (int i = 0; i < T_MAX; i++) xmem[i] = rnd_x();
    #1;
    test_reset();
    test_basic();
    test_zero_len();
    test_clamp();
    test_backpressure();
    test_reverse_order();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
